day05_range_query_scheduler: RTL and testbench

- Shares one merged-range lookup table, and the binary-search engine that reads it, among N_REQ independent ID requesters (parallel value parsers).
- Arbitrates round-robin, runs an inclusive-bound binary search per accepted query, and returns hit/miss tagged with the requester ID.
- Keeps running part-1 totals.
- Sits between the value-parsing front ends and the merged-range RAM, once the merge stage has populated that RAM.

---
 rtl/day05_range_query_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_day05_range_query_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/day05_range_query_scheduler.sv
// day05_range_query_scheduler
//   Shares one merged-range lookup table and its binary-search engine among
//   N_REQ requesters. Requests are granted round-robin, one query is in flight
//   at a time, and every completed query returns a one-cycle hit/miss strobe
//   tagged with the requester ID. Running hit and query totals are kept.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   req_valid    per-requester query valid (held until req_ready)
//   req_value    requester i value at [i*VAL_W +: VAL_W]
//   req_ready    one-hot accept pulse, combinational in the ARB state
//   resp_valid   one-cycle response strobe
//   resp_id      requester the response belongs to
//   resp_hit     1 = value lies inside some table range
//   tbl_ready    table contents and tbl_count are valid and stable
//   tbl_count    number of table entries
//   tbl_addr     registered table read address
//   tbl_rdata    table[tbl_addr] = {low, high}, both inclusive
//   hit_count    total hits (wraps at 2^64)
//   query_count  total completed queries (wraps at 2^64)
module day05_range_query_scheduler #(
  parameter int N_REQ           = 4,
  parameter int LOG2_N_REQ      = 2,
  parameter int VAL_W           = 64,
  parameter int LOG2_MAX_RANGES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*VAL_W-1:0]     req_value,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       resp_valid,
  output logic [LOG2_N_REQ-1:0]      resp_id,
  output logic                       resp_hit,
  input  logic                       tbl_ready,
  input  logic [LOG2_MAX_RANGES:0]   tbl_count,
  output logic [LOG2_MAX_RANGES-1:0] tbl_addr,
  input  logic [2*VAL_W-1:0]         tbl_rdata,
  output logic [63:0]                hit_count,
  output logic [63:0]                query_count
);

  // Search indices carry one bit of headroom beyond the signed table index so
  // that low = addr+1 past the last possible entry cannot wrap negative; -1 is
  // still representable for an empty table or a miss below entry 0.
  localparam int IDX_W = LOG2_MAX_RANGES + 2;

  typedef enum logic [1:0] {ARB, LOOP, EVAL, RESP} state_e;

  state_e                     state_q, state_d;
  logic [LOG2_N_REQ-1:0]      rr_ptr_q, rr_ptr_d;
  logic [LOG2_N_REQ-1:0]      id_q, id_d;
  logic                       hit_q, hit_d;
  logic [LOG2_MAX_RANGES-1:0] addr_q, addr_d;
  logic [63:0]                hit_cnt_q, hit_cnt_d;
  logic [63:0]                qry_cnt_q, qry_cnt_d;
  logic [VAL_W-1:0]           val_q, val_d;
  logic signed [IDX_W-1:0]    low_q, low_d;
  logic signed [IDX_W-1:0]    high_q, high_d;

  logic                       grant_any;
  logic                       do_grant;
  logic [LOG2_N_REQ-1:0]      grant_id;
  logic [LOG2_N_REQ-1:0]      scan_idx;
  logic signed [IDX_W-1:0]    mid;
  logic signed [IDX_W-1:0]    addr_ext;
  logic [VAL_W-1:0]           low_b;
  logic [VAL_W-1:0]           high_b;

  assign low_b    = tbl_rdata[2*VAL_W-1:VAL_W];
  assign high_b   = tbl_rdata[VAL_W-1:0];
  assign addr_ext = $signed({2'b00, addr_q});

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    // NOTE: every variable written here is given a value before any branch,
    // so no path through the block can infer a latch.
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = LOG2_N_REQ'((int'(rr_ptr_q) + k) % N_REQ);
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  assign do_grant  = (state_q == ARB) && tbl_ready && grant_any;
  assign req_ready = do_grant ? (N_REQ'(1) << grant_id) : '0;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    hit_d     = hit_q;
    addr_d    = addr_q;
    hit_cnt_d = hit_cnt_q;
    qry_cnt_d = qry_cnt_q;
    val_d     = val_q;
    low_d     = low_q;
    high_d    = high_q;
    mid       = low_q + ((high_q - low_q) >>> 1);

    unique case (state_q)
      ARB: begin
        if (do_grant) begin
          rr_ptr_d = grant_id;
          id_d     = grant_id;
          val_d    = req_value[int'(grant_id)*VAL_W +: VAL_W];
          hit_d    = 1'b0;
          low_d    = '0;
          // An empty table yields high = -1, so LOOP reports a miss at once.
          high_d   = $signed({1'b0, tbl_count}) - IDX_W'(1);
          state_d  = LOOP;
        end
      end
      LOOP: begin
        if (low_q > high_q) begin
          hit_d   = 1'b0;
          state_d = RESP;
        end else begin
          addr_d  = LOG2_MAX_RANGES'(mid);
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Both bounds inclusive; only plain compares, no value+1 arithmetic.
        if (val_q >= low_b && val_q <= high_b) begin
          hit_d   = 1'b1;
          state_d = RESP;
        end else if (val_q < low_b) begin
          high_d  = addr_ext - IDX_W'(1);
          state_d = LOOP;
        end else begin
          low_d   = addr_ext + IDX_W'(1);
          state_d = LOOP;
        end
      end
      RESP: begin
        qry_cnt_d = qry_cnt_q + 64'd1;
        if (hit_q) hit_cnt_d = hit_cnt_q + 64'd1;
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      rr_ptr_q  <= LOG2_N_REQ'(N_REQ - 1);
      id_q      <= '0;
      hit_q     <= 1'b0;
      addr_q    <= '0;
      hit_cnt_q <= '0;
      qry_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      hit_q     <= hit_d;
      addr_q    <= addr_d;
      hit_cnt_q <= hit_cnt_d;
      qry_cnt_q <= qry_cnt_d;
    end
  end

  // NOTE: the search datapath is left unreset; it is always loaded on a grant
  // before the FSM reads it.
  always_ff @(posedge clk) begin
    val_q  <= val_d;
    low_q  <= low_d;
    high_q <= high_d;
  end

  assign resp_valid  = (state_q == RESP);
  assign resp_id     = id_q;
  assign resp_hit    = hit_q;
  assign tbl_addr    = addr_q;
  assign hit_count   = hit_cnt_q;
  assign query_count = qry_cnt_q;

endmodule

// File: tb/tb_day05_range_query_scheduler.sv
// Self-checking bench for day05_range_query_scheduler. Accepted queries are
// turned into expected responses (requester, hit, cycle) by a reference model
// of the range table and pushed to a scoreboard; a monitor pops and compares
// whenever resp_valid is seen.
module tb_day05_range_query_scheduler;

  localparam int N_REQ = 4;
  localparam int LOG2_N_REQ = 2;
  localparam int VAL_W = 64;
  localparam int LOG2_MAX_RANGES = 8;
  localparam int MAX_RANGES = 1 << LOG2_MAX_RANGES;

  logic                       clk;
  logic                       rst;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*VAL_W-1:0]     req_value;
  logic [N_REQ-1:0]           req_ready;
  logic                       resp_valid;
  logic [LOG2_N_REQ-1:0]      resp_id;
  logic                       resp_hit;
  logic                       tbl_ready;
  logic [LOG2_MAX_RANGES:0]   tbl_count;
  logic [LOG2_MAX_RANGES-1:0] tbl_addr;
  logic [2*VAL_W-1:0]         tbl_rdata;
  logic [63:0]                hit_count;
  logic [63:0]                query_count;

  logic [VAL_W-1:0] t_lo [MAX_RANGES];
  logic [VAL_W-1:0] t_hi [MAX_RANGES];

  assign tbl_rdata = {t_lo[tbl_addr], t_hi[tbl_addr]};

  day05_range_query_scheduler #(
    .N_REQ(N_REQ), .LOG2_N_REQ(LOG2_N_REQ), .VAL_W(VAL_W),
    .LOG2_MAX_RANGES(LOG2_MAX_RANGES)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_hit(resp_hit),
    .tbl_ready(tbl_ready), .tbl_count(tbl_count), .tbl_addr(tbl_addr),
    .tbl_rdata(tbl_rdata), .hit_count(hit_count), .query_count(query_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    bit hit;
    int due;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   grant_cnt[N_REQ];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: hit is "value lies inside any listed range"; probe count is the
  // number of table reads a midpoint binary search over the sorted list makes.
  function automatic void model(input logic [VAL_W-1:0] v, output bit hit, output int probes);
    int lo;
    int hi;
    int m;
    bit found;
    hit = 1'b0;
    for (int i = 0; i < int'(tbl_count); i++)
      if (v >= t_lo[i] && v <= t_hi[i]) hit = 1'b1;
    lo = 0;
    hi = int'(tbl_count) - 1;
    probes = 0;
    found = 1'b0;
    while (!found && lo <= hi) begin
      m = (lo + hi) / 2;
      probes++;
      if (v >= t_lo[m] && v <= t_hi[m]) found = 1'b1;
      else if (v < t_lo[m]) hi = m - 1;
      else lo = m + 1;
    end
  endfunction

  // Monitor: arbitration model, scoreboard push on accept, pop on response.
  initial begin : monitor
    logic [N_REQ-1:0] exp_ready;
    logic [63:0]      exp_hits;
    logic [63:0]      exp_queries;
    int               last_grant;
    int               g;
    int               idx;
    int               probes;
    bit               h;
    exp_t             e;
    exp_hits = '0;
    exp_queries = '0;
    last_grant = N_REQ - 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        last_grant = N_REQ - 1;
        exp_hits = '0;
        exp_queries = '0;
      end else begin
        check("hit_count", hit_count, exp_hits);
        check("query_count", query_count, exp_queries);
        exp_ready = '0;
        g = -1;
        if (sb.size() == 0 && tbl_ready) begin
          for (int j = 1; j <= N_REQ; j++) begin
            idx = (last_grant + j) % N_REQ;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        if (g >= 0) begin
          model(req_value[g*VAL_W +: VAL_W], h, probes);
          e.id = g;
          e.hit = h;
          e.due = cyc + (h ? 2 * probes + 1 : 2 * probes + 2);
          sb.push_back(e);
          last_grant = g;
        end
        for (int j = 0; j < N_REQ; j++) begin
          if (req_ready[j]) begin
            grant_cnt[j]++;
            grant_log.push_back(j);
          end
        end
        if (resp_valid) begin
          if (sb.size() == 0) begin
            check("resp_unexpected", resp_valid, 1'b0);
          end else begin
            e = sb.pop_front();
            check("resp_id", resp_id, e.id);
            check("resp_hit", resp_hit, e.hit);
            check("resp_cycle", cyc, e.due);
            exp_queries = exp_queries + 64'd1;
            if (e.hit) exp_hits = exp_hits + 64'd1;
          end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
          check("resp_timeout", resp_valid, 1'b1);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Present values on the masked requesters and drop each one once accepted.
  task automatic send(input logic [N_REQ-1:0] mask, input logic [VAL_W-1:0] v0,
                      input logic [VAL_W-1:0] v1, input logic [VAL_W-1:0] v2,
                      input logic [VAL_W-1:0] v3, input bit jitter);
    int base[N_REQ];
    logic [VAL_W-1:0] vals[N_REQ];
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    @(posedge clk); #1;
    for (int i = 0; i < N_REQ; i++) begin
      base[i] = grant_cnt[i];
      if (mask[i]) begin
        req_valid[i] = 1'b1;
        req_value[i*VAL_W +: VAL_W] = vals[i];
      end
    end
    if (jitter) tbl_ready = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < 400 && req_valid != '0; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i] && grant_cnt[i] != base[i]) req_valid[i] = 1'b0;
      if (jitter) tbl_ready = ($urandom_range(0, 3) != 0);
    end
    check("send_accepted", req_valid, '0);
    req_valid = '0;
    tbl_ready = 1'b1;
  endtask

  task automatic send1(input int id, input logic [VAL_W-1:0] v);
    logic [N_REQ-1:0] m;
    m = '0;
    m[id] = 1'b1;
    send(m, v, v, v, v, 1'b0);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (sb.size() == 0) break;
    end
    check("idle", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_demo_table();
    t_lo[0] = 64'd3;  t_hi[0] = 64'd5;
    t_lo[1] = 64'd10; t_hi[1] = 64'd20;
    t_lo[2] = 64'd25; t_hi[2] = 64'd30;
    tbl_count = 9'd3;
  endtask

  task automatic rand_table();
    int n;
    n = $urandom_range(0, 12);
    for (int k = 0; k < n; k++) begin
      t_lo[k] = (64'(k) << 60) + 64'($urandom_range(0, 1 << 20));
      t_hi[k] = t_lo[k] + 64'($urandom_range(0, 1 << 20));
    end
    if (n > 0 && $urandom_range(0, 1) == 1) t_lo[0] = '0;
    if (n > 0 && $urandom_range(0, 1) == 1) t_hi[n-1] = '1;
    tbl_count = 9'(n);
  endtask

  function automatic logic [VAL_W-1:0] rand_val();
    int n;
    int m;
    int e;
    logic [VAL_W-1:0] v;
    n = int'(tbl_count);
    m = $urandom_range(0, 5);
    v = {$urandom, $urandom};
    if (n > 0 && m < 5) begin
      e = $urandom_range(0, n - 1);
      case (m)
        0: v = t_lo[e];
        1: v = t_hi[e];
        2: v = t_lo[e] - 64'd1;
        3: v = t_hi[e] + 64'd1;
        default: v = t_lo[e] + (t_hi[e] - t_lo[e]) / 2;
      endcase
    end
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base;
    logic [LOG2_MAX_RANGES-1:0] addr_before;
    rst = 1'b1;
    req_valid = '0;
    req_value = '0;
    tbl_ready = 1'b1;
    tbl_count = '0;
    for (int i = 0; i < MAX_RANGES; i++) begin
      t_lo[i] = '0;
      t_hi[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_req_ready", req_ready, '0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_id", resp_id, '0);
    check("rst_resp_hit", resp_hit, 1'b0);
    check("rst_tbl_addr", tbl_addr, '0);
    check("rst_hit_count", hit_count, '0);
    check("rst_query_count", query_count, '0);

    // Demo table queries: hits on probe 1 and 2, misses below and between.
    load_demo_table();
    send1(0, 64'd17); wait_idle();
    check("first_hit_count", hit_count, 64'd1);
    check("first_query_count", query_count, 64'd1);
    send1(1, 64'd1);  wait_idle();
    send1(2, 64'd30); wait_idle();
    send1(3, 64'd21); wait_idle();
    send1(2, 64'd3);  wait_idle();
    send1(3, 64'd5);  wait_idle();

    // Four simultaneous requests after reset are served 0,1,2,3.
    do_reset();
    base = grant_log.size();
    send(4'hF, 64'd4, 64'd8, 64'd25, 64'd31, 1'b0);
    wait_idle();
    check("fourway_grants", grant_log.size() - base, 4);
    for (int i = 0; i < 4 && base + i < grant_log.size(); i++)
      check("fourway_order", grant_log[base+i], i);
    check("fourway_hit_count", hit_count, 64'd2);
    check("fourway_query_count", query_count, 64'd4);

    // After requester 1 is served, requester 2 outranks requester 0.
    send1(1, 64'd17); wait_idle();
    base = grant_log.size();
    send(4'b0101, 64'd5, 64'd0, 64'd12, 64'd0, 1'b0);
    wait_idle();
    check("rr_grants", grant_log.size() - base, 2);
    if (grant_log.size() - base >= 2) begin
      check("rr_first", grant_log[base], 2);
      check("rr_second", grant_log[base+1], 0);
    end

    // Empty table: immediate miss, no probe.
    tbl_count = '0;
    addr_before = tbl_addr;
    send1(0, 64'd7); wait_idle();
    check("empty_no_probe", tbl_addr, addr_before);
    load_demo_table();

    // tbl_ready low blocks grants; raising it grants in the same cycle.
    @(posedge clk); #1;
    tbl_ready = 1'b0;
    req_valid[1] = 1'b1;
    req_value[1*VAL_W +: VAL_W] = 64'd21;
    repeat (10) begin
      @(negedge clk);
      check("blocked_ready", req_ready, '0);
    end
    @(posedge clk); #1;
    tbl_ready = 1'b1;
    @(negedge clk);
    check("raise_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Reset during EVAL discards the query and restores requester 0 priority.
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_value[1*VAL_W +: VAL_W] = 64'd1;
    @(negedge clk);
    check("mid_accept", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_hits", hit_count, '0);
    check("mid_rst_queries", query_count, '0);
    check("mid_rst_resp", resp_valid, 1'b0);
    base = grant_log.size();
    send(4'b0101, 64'd17, 64'd0, 64'd1, 64'd0, 1'b0);
    wait_idle();
    check("post_rst_grants", grant_log.size() - base, 2);
    if (grant_log.size() - base >= 2) begin
      check("post_rst_first", grant_log[base], 0);
      check("post_rst_second", grant_log[base+1], 2);
    end

    // Value extremes against inclusive bounds at 0 and all-ones.
    t_lo[0] = 64'd0;   t_hi[0] = 64'd5;
    t_lo[1] = 64'd100; t_hi[1] = '1;
    tbl_count = 9'd2;
    send1(0, 64'd0);   wait_idle();
    send1(1, '1);      wait_idle();
    send1(2, 64'd6);   wait_idle();
    send1(3, 64'd99);  wait_idle();
    send1(0, 64'd100); wait_idle();

    // Randomized tables, request masks, values and tbl_ready jitter.
    for (int it = 0; it < 80; it++) begin
      if (it % 8 == 0) begin
        wait_idle();
        rand_table();
      end
      send(4'($urandom_range(1, 15)), rand_val(), rand_val(), rand_val(), rand_val(), 1'b1);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
